arc4_prga_param: RTL
====================

Name: arc4_prga_param

Overview:
- Parametrised ARC4 keystream generator and decryptor. It runs after KSA has filled the S memory.
- Reads a length-prefixed ciphertext from CT memory, generates the PRGA keystream from S (swapping in place), and writes the length-prefixed plaintext to PT memory.
- Generalises the fixed single-cycle-memory version in three ways: configurable memory read latency, configurable length width, and an optional printable-ASCII check with early abort. The check lets the key-search controller reject keys without decrypting the whole message.

Parameters:
- MEM_LAT, 1, read latency in cycles of the S and CT memories; legal range 1..3.
- CHECK_ASCII, 0, 1 enables the plaintext range check and early abort.
- ASCII_LO, 8'h20, lowest plaintext byte accepted when CHECK_ASCII=1.
- ASCII_HI, 8'h7E, highest plaintext byte accepted when CHECK_ASCII=1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  idle and ready to accept en.
- done  out  1  one-cycle pulse on completion or abort.
- key_ok  out  1  result flag; valid from the done pulse until the next accepted en.
- s_addr  out  8  S memory address.
- s_rddata  in  8  S read data, valid MEM_LAT cycles after s_addr.
- s_wrdata  out  8  S write data.
- s_wren  out  1  S write enable.
- ct_addr  out  8  CT memory address.
- ct_rddata  in  8  CT read data, valid MEM_LAT cycles after ct_addr.
- pt_addr  out  8  PT memory address.
- pt_wrdata  out  8  PT write data.
- pt_wren  out  1  PT write enable.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE; rdy=1, done=0, key_ok=0.
  - All addresses, write data and write enables are 0.
  - Internal i, j, k, len are cleared.
  - Reset mid-operation abandons the run; memory contents are not restored.
- Handshake:
  - en with rdy=1 is accepted at that edge; rdy=0 from the next cycle until completion.
  - en while rdy=0 is ignored.
  - When the run ends: done pulses for 1 cycle, and rdy returns to 1 in the same cycle.
  - en in the done cycle starts a new run.
- Write enables: s_wren and pt_wren are high for exactly one cycle per write and are 0 in every other state.
- Message format: ct[0]=len (0..255), ciphertext at ct[1..len]; pt[0]=len, plaintext at pt[1..len].
- All arithmetic is 8-bit modulo 256.
- A WAIT(n) is a counter stall of n=MEM_LAT cycles after an address is issued, before the data is sampled.
- State sequence and per-state actions:
  - IDLE: on accept, i=0, j=0, k=1, key_ok=1; issue ct_addr=0; go to WAIT(MEM_LAT), then LEN.
  - LEN: len=ct_rddata; write pt[0]=len. If len=0, go to FIN; else go to RD_I.
  - RD_I: i=i+1; s_addr=i; WAIT; then si=s_rddata, j=j+si.
  - RD_J: s_addr=j; WAIT; then sj=s_rddata.
  - WR_I: write S[i]=sj.
  - WR_J: write S[j]=si. When i=j, the WR_J write wins, which is the correct result.
  - RD_PAD: s_addr=si+sj and ct_addr=k, issued in the same cycle; WAIT.
  - XOR_WR: write pt[k]=s_rddata^ct_rddata. If CHECK_ASCII=1 and the byte is outside [ASCII_LO, ASCII_HI], key_ok=0 and go to FIN; the failing byte is still written. Else, if k=len go to FIN; else k=k+1 and go to RD_I.
  - FIN: done=1, rdy=1, go to IDLE.
- Per-byte cost: 6 + 3*MEM_LAT cycles.
- When CHECK_ASCII=0, key_ok stays 1 for the whole run.
- k never exceeds len; the len=255 wrap is covered by the k=len test occurring before the increment.

Test Plan:
- S preloaded identity (S[x]=x), ct={3,AA,BB,CC}, MEM_LAT=1, CHECK_ASCII=0 -> pt={03,A8,BE,CB}; S[0..7]={0,1,3,5,4,2,6,7}; done pulses once; key_ok=1; rdy=0 throughout the run.
- Same stimulus with MEM_LAT=3 (bench model delays read data by 3 cycles) -> identical pt and S contents; byte-phase cycle count = 3*15.
- CHECK_ASCII=1, identity S, ct={2,43,00} -> pt[1]=41 accepted; pt[2]=05 is written; then abort with key_ok=0. done arrives before any further ct read; pt[0]=02.
- ct={0}, identity S -> pt[0]=00 only; no S writes; done within 3+MEM_LAT cycles of en; key_ok=1.
- Assert en repeatedly mid-run -> ignored; the output is unchanged versus the first test. Then deassert rst_n during RD_J -> rdy=1, done=0, all wren=0 immediately; a fresh en after reset with re-initialised memories reproduces the first test.
- Back-to-back runs: en held high in the done cycle -> second run starts with i=j=0, k=1, key_ok=1, and produces the correct result against the S left by the first run.

Source files
------------

// File: rtl/arc4_prga_param.sv
// ARC4 PRGA stage: reads a length-prefixed ciphertext, generates the keystream
// from the S memory that KSA left behind (swapping in place), and writes the
// length-prefixed plaintext. Memory read latency is MEM_LAT cycles. An
// optional printable-range check aborts early and clears key_ok.
module arc4_prga_param #(
  parameter int unsigned MEM_LAT     = 1,
  parameter int unsigned CHECK_ASCII = 0,
  parameter logic [7:0]  ASCII_LO    = 8'h20,
  parameter logic [7:0]  ASCII_HI    = 8'h7E
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic       done,
  output logic       key_ok,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_W_LEN, ST_LEN, ST_RD_I, ST_W_I, ST_RD_J, ST_W_J,
    ST_WR_I, ST_WR_J, ST_RD_PAD, ST_W_PAD, ST_XOR_WR, ST_FIN
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d;
  logic [7:0] si_q, si_d, sj_q, sj_d;
  logic       key_ok_q, key_ok_d;
  logic [1:0] cnt_q, cnt_d;
  logic       wait_last;
  logic [7:0] pad;
  logic       pad_bad;

  assign wait_last = (cnt_q == 2'(MEM_LAT - 1));
  assign pad       = s_rddata ^ ct_rddata;
  assign pad_bad   = (CHECK_ASCII != 0) && ((pad < ASCII_LO) || (pad > ASCII_HI));

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      len_q    <= '0;
      si_q     <= '0;
      sj_q     <= '0;
      key_ok_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      len_q    <= len_d;
      si_q     <= si_d;
      sj_q     <= sj_d;
      key_ok_q <= key_ok_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and datapath updates; i is incremented on entry to RD_I so the
  // address is already stable during the RD_I cycle.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    len_d    = len_q;
    si_d     = si_q;
    sj_d     = sj_q;
    key_ok_d = key_ok_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (en) begin
          state_d  = ST_W_LEN;
          i_d      = '0;
          j_d      = '0;
          k_d      = 8'd1;
          key_ok_d = 1'b1;
          cnt_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_W_LEN: begin
        cnt_d = wait_last ? '0 : cnt_q + 2'd1;
        if (wait_last) state_d = ST_LEN;
      end
      ST_LEN: begin
        len_d = ct_rddata;
        if (ct_rddata == 8'd0) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_RD_I;
          i_d     = i_q + 8'd1;
        end
      end
      ST_RD_I: state_d = ST_W_I;
      ST_W_I: begin
        cnt_d = wait_last ? '0 : cnt_q + 2'd1;
        if (wait_last) begin
          si_d    = s_rddata;
          j_d     = j_q + s_rddata;
          state_d = ST_RD_J;
        end
      end
      ST_RD_J: state_d = ST_W_J;
      ST_W_J: begin
        cnt_d = wait_last ? '0 : cnt_q + 2'd1;
        if (wait_last) begin
          sj_d    = s_rddata;
          state_d = ST_WR_I;
        end
      end
      ST_WR_I:   state_d = ST_WR_J;
      ST_WR_J:   state_d = ST_RD_PAD;
      ST_RD_PAD: state_d = ST_W_PAD;
      ST_W_PAD: begin
        cnt_d = wait_last ? '0 : cnt_q + 2'd1;
        if (wait_last) state_d = ST_XOR_WR;
      end
      ST_XOR_WR: begin
        if (pad_bad) begin
          key_ok_d = 1'b0;
          state_d  = ST_FIN;
        end else if (k_q == len_q) begin
          state_d = ST_FIN;
        end else begin
          k_d     = k_q + 8'd1;
          i_d     = i_q + 8'd1;
          state_d = ST_RD_I;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory-side outputs decoded from state; addresses are held through the
  // wait states so the read data is still valid when it is consumed.
  always_comb begin
    rdy       = (state_q == ST_IDLE) || (state_q == ST_FIN);
    done      = (state_q == ST_FIN);
    key_ok    = key_ok_q;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;
    case (state_q)
      ST_LEN: begin
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
      end
      ST_RD_I, ST_W_I: s_addr = i_q;
      ST_RD_J, ST_W_J: s_addr = j_q;
      ST_WR_I: begin
        s_addr   = i_q;
        s_wrdata = sj_q;
        s_wren   = 1'b1;
      end
      ST_WR_J: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
      end
      ST_RD_PAD, ST_W_PAD: begin
        s_addr  = si_q + sj_q;
        ct_addr = k_q;
      end
      ST_XOR_WR: begin
        s_addr    = si_q + sj_q;
        ct_addr   = k_q;
        pt_addr   = k_q;
        pt_wrdata = pad;
        pt_wren   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
